// File: rtl/fft_pingpong_bram.sv
// Ping-pong sample store: streaming fill into one bank, dual random-access compute ports on the other.
// Latency: compute reads return READ_LATENCY cycles after the address; bank swap takes effect at the completing edge.
// Backpressure: fill_ready drops when the fill bank is full and the FFT still owns the other bank.
module fft_pingpong_bram #(
  parameter  int POINTS       = 1024,
  parameter  int SAMPLE_WIDTH = 32,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_W       = $clog2(POINTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_valid,
  input  logic [SAMPLE_WIDTH-1:0] fill_data,
  output logic                    fill_ready,
  output logic                    comp_valid,
  output logic                    comp_bank,
  input  logic                    comp_done,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic [SAMPLE_WIDTH-1:0] din_a,
  input  logic [SAMPLE_WIDTH-1:0] din_b,
  input  logic                    we_a,
  input  logic                    we_b,
  output logic [SAMPLE_WIDTH-1:0] dout_a,
  output logic [SAMPLE_WIDTH-1:0] dout_b,
  output logic                    collision,
  output logic                    done_err,
  output logic [15:0]             frame_cnt
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(POINTS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(POINTS - 1);

  // Both banks in one array, indexed {bank, addr}; contents are deliberately not reset.
  logic [SAMPLE_WIDTH-1:0] mem [2*POINTS];

  logic                    fill_bank_q, fill_bank_d;
  logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic                    comp_busy_q, comp_busy_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    collision_q, collision_d;
  logic                    done_err_q, done_err_d;
  logic [SAMPLE_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [SAMPLE_WIDTH-1:0] rd_b_q, rd_b_d;

  logic fill_acc;
  logic fill_complete;
  logic comp_free;
  logic swap;
  logic comp_wr_a;
  logic comp_wr_b;

  assign comp_bank  = ~fill_bank_q;
  assign comp_valid = comp_busy_q;
  assign collision  = collision_q;
  assign done_err   = done_err_q;
  assign frame_cnt  = frame_cnt_q;

  // Fill/swap bookkeeping, error pulses and read-address decode.
  always_comb begin
    fill_ready    = (fill_cnt_q != CNT_FULL);
    fill_acc      = fill_valid && fill_ready;
    fill_complete = (fill_cnt_q == CNT_FULL) || ((fill_cnt_q == CNT_LAST) && fill_acc);
    comp_free     = !comp_busy_q || comp_done;
    swap          = fill_complete && comp_free;
    comp_wr_a     = comp_busy_q && we_a;
    comp_wr_b     = comp_busy_q && we_b;

    fill_bank_d   = fill_bank_q;
    fill_cnt_d    = fill_cnt_q;
    comp_busy_d   = comp_busy_q;
    frame_cnt_d   = frame_cnt_q;

    if (swap) begin
      fill_bank_d = ~fill_bank_q;
      fill_cnt_d  = '0;
      comp_busy_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      if (fill_acc) begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
      if (comp_done && comp_busy_q) begin
        comp_busy_d = 1'b0;
      end
    end

    collision_d = comp_wr_a && comp_wr_b && (addr_a == addr_b);
    done_err_d  = comp_done && !comp_busy_q;

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    rd_a_d = mem[{comp_bank, addr_a}];
    rd_b_d = mem[{comp_bank, addr_b}];
  end

  // Control state and first read stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank_q <= 1'b0;
      fill_cnt_q  <= '0;
      comp_busy_q <= 1'b0;
      frame_cnt_q <= '0;
      collision_q <= 1'b0;
      done_err_q  <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
    end else begin
      fill_bank_q <= fill_bank_d;
      fill_cnt_q  <= fill_cnt_d;
      comp_busy_q <= comp_busy_d;
      frame_cnt_q <= frame_cnt_d;
      collision_q <= collision_d;
      done_err_q  <= done_err_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
    end
  end

  // Array writes; port A is written last so it wins a same-address conflict with port B.
  always_ff @(posedge clk) begin
    if (fill_acc && rst_n) begin
      mem[{fill_bank_q, fill_cnt_q[ADDR_W-1:0]}] <= fill_data;
    end
    if (comp_wr_b) begin
      mem[{comp_bank, addr_b}] <= din_b;
    end
    if (comp_wr_a) begin
      mem[{comp_bank, addr_a}] <= din_a;
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic [SAMPLE_WIDTH-1:0] pipe_a_q;
    logic [SAMPLE_WIDTH-1:0] pipe_b_q;

    // Optional second read stage: plain pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_a_q <= '0;
        pipe_b_q <= '0;
      end else begin
        pipe_a_q <= rd_a_q;
        pipe_b_q <= rd_b_q;
      end
    end

    assign dout_a = pipe_a_q;
    assign dout_b = pipe_b_q;
  end else begin : g_rl1
    assign dout_a = rd_a_q;
    assign dout_b = rd_b_q;
  end

endmodule

// File: tb/tb_fft_pingpong_bram.sv
// Bench for fft_pingpong_bram: two instances (read latency 1 and 2) share all inputs.
// A behavioural bank/frame model updates at each rising edge; outputs are checked 1 ns later.
// Scenario tasks run in sequence and end with a single summary line.
module tb_fft_pingpong_bram;

  localparam int P  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          fill_valid;
  logic [31:0]   fill_data;
  logic          comp_done;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0]   din_a, din_b;
  logic          we_a, we_b;

  logic        fill_ready_1, comp_valid_1, comp_bank_1, collision_1, done_err_1;
  logic [31:0] dout_a_1, dout_b_1;
  logic [15:0] frame_cnt_1;
  logic        fill_ready_2, comp_valid_2, comp_bank_2, collision_2, done_err_2;
  logic [31:0] dout_a_2, dout_b_2;
  logic [15:0] frame_cnt_2;

  int n_pass;
  int n_tot;

  fft_pingpong_bram #(.POINTS(P), .SAMPLE_WIDTH(32), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(fill_ready_1), .comp_valid(comp_valid_1), .comp_bank(comp_bank_1),
    .comp_done(comp_done), .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .we_a(we_a), .we_b(we_b), .dout_a(dout_a_1), .dout_b(dout_b_1),
    .collision(collision_1), .done_err(done_err_1), .frame_cnt(frame_cnt_1)
  );

  fft_pingpong_bram #(.POINTS(P), .SAMPLE_WIDTH(32), .READ_LATENCY(2)) u_rl2 (
    .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(fill_ready_2), .comp_valid(comp_valid_2), .comp_bank(comp_bank_2),
    .comp_done(comp_done), .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .we_a(we_a), .we_b(we_b), .dout_a(dout_a_2), .dout_b(dout_b_2),
    .collision(collision_2), .done_err(done_err_2), .frame_cnt(frame_cnt_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem   [2*P];
  bit          m_known [2*P];
  bit          m_fb;
  int          m_cnt;
  bit          m_busy;
  logic [15:0] m_frame;
  bit          m_coll, m_derr;
  logic [31:0] ea1, eb1, ea2, eb2;
  bit          ka1, kb1, ka2, kb2;

  task automatic model_reset();
    m_fb = 0; m_cnt = 0; m_busy = 0; m_frame = 16'd0; m_coll = 0; m_derr = 0;
    ea1 = 32'd0; eb1 = 32'd0; ea2 = 32'd0; eb2 = 32'd0;
    ka1 = 1; kb1 = 1; ka2 = 1; kb2 = 1;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_step();
    int  cb, ia, ib;
    bit  acc;
    if (!rst_n) return;
    cb  = m_fb ? 0 : 1;
    ia  = cb * P + int'(addr_a);
    ib  = cb * P + int'(addr_b);
    acc = fill_valid && (m_cnt != P);
    ea2 = ea1; ka2 = ka1; eb2 = eb1; kb2 = kb1;
    ea1 = m_mem[ia]; ka1 = m_known[ia];
    eb1 = m_mem[ib]; kb1 = m_known[ib];
    if (acc) begin
      m_mem[int'(m_fb) * P + m_cnt]   = fill_data;
      m_known[int'(m_fb) * P + m_cnt] = 1;
      m_cnt++;
    end
    m_coll = m_busy && we_a && we_b && (addr_a == addr_b);
    if (m_busy && we_b) begin m_mem[ib] = din_b; m_known[ib] = 1; end
    if (m_busy && we_a) begin m_mem[ia] = din_a; m_known[ia] = 1; end
    m_derr = comp_done && !m_busy;
    if (m_cnt == P && (!m_busy || comp_done)) begin
      m_fb = !m_fb; m_cnt = 0; m_busy = 1; m_frame = m_frame + 16'd1;
    end else if (comp_done && m_busy) begin
      m_busy = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    fill_valid = 0; comp_done = 0; we_a = 0; we_b = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; set_idle();
    fill_data = 32'd0; addr_a = '0; addr_b = '0; din_a = 32'd0; din_b = 32'd0;
    for (int i = 0; i < 2 * P; i++) m_known[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tot++; if (fill_ready_1 !== 1'b1) $display("FAIL reset_fill_ready got %b exp 1", fill_ready_1); else n_pass++;
    n_tot++; if (comp_valid_1 !== 1'b0) $display("FAIL reset_comp_valid got %b exp 0", comp_valid_1); else n_pass++;
    n_tot++; if (comp_bank_1 !== 1'b1) $display("FAIL reset_comp_bank got %b exp 1", comp_bank_1); else n_pass++;
    n_tot++; if (frame_cnt_1 !== 16'd0) $display("FAIL reset_frame got %0d exp 0", frame_cnt_1); else n_pass++;
    n_tot++; if ({collision_1, done_err_1, collision_2, done_err_2} !== 4'b0) $display("FAIL reset_pulses got %b exp 0000", {collision_1, done_err_1, collision_2, done_err_2}); else n_pass++;
    n_tot++; if ({dout_a_1, dout_b_1, dout_a_2, dout_b_2} !== 128'd0) $display("FAIL reset_dout got %h exp 0", {dout_a_1, dout_b_1, dout_a_2, dout_b_2}); else n_pass++;
    rst_n = 1;
  endtask

  task automatic test_fill_swap();
    for (int i = 0; i < P; i++) begin
      fill_valid = 1; fill_data = 32'(i);
      cyc();
      n_tot++; if (fill_ready_1 !== 1'b1) $display("FAIL fill_ready_steady cyc %0d got %b exp 1", i, fill_ready_1); else n_pass++;
      if (i == P - 2) begin
        n_tot++; if (comp_valid_1 !== 1'b0) $display("FAIL early_comp_valid got %b exp 0", comp_valid_1); else n_pass++;
      end
    end
    fill_valid = 0;
    n_tot++; if (comp_valid_1 !== 1'b1) $display("FAIL swap_comp_valid got %b exp 1", comp_valid_1); else n_pass++;
    n_tot++; if (comp_bank_1 !== 1'b0) $display("FAIL swap_comp_bank got %b exp 0", comp_bank_1); else n_pass++;
    n_tot++; if (frame_cnt_1 !== 16'd1) $display("FAIL swap_frame got %0d exp 1", frame_cnt_1); else n_pass++;
    // Sequential read-back of the frame on port A, random addresses on port B.
    for (int i = 0; i <= P; i++) begin
      addr_a = AW'(i); addr_b = AW'($urandom_range(P - 1));
      cyc();
      if (i < P) begin
        n_tot++; if (dout_a_1 !== 32'(i)) $display("FAIL readback_rl1 addr %0d got %h exp %h", i, dout_a_1, 32'(i)); else n_pass++;
      end
      if (i >= 1) begin
        n_tot++; if (dout_a_2 !== 32'(i - 1)) $display("FAIL readback_rl2 addr %0d got %h exp %h", i - 1, dout_a_2, 32'(i - 1)); else n_pass++;
      end
      if (kb1) begin
        n_tot++; if (dout_b_1 !== eb1) $display("FAIL readback_b got %h exp %h", dout_b_1, eb1); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < P + 3; i++) begin
      fill_valid = 1; fill_data = $urandom;
      cyc();
      n_tot++; if (fill_ready_1 !== (i < P - 1)) $display("FAIL bp_fill_ready cyc %0d got %b exp %b", i, fill_ready_1, (i < P - 1)); else n_pass++;
    end
    n_tot++; if (frame_cnt_1 !== 16'd1) $display("FAIL bp_frame_held got %0d exp 1", frame_cnt_1); else n_pass++;
    fill_valid = 0; comp_done = 1;
    cyc();
    comp_done = 0;
    n_tot++; if (comp_bank_1 !== 1'b1) $display("FAIL bp_comp_bank got %b exp 1", comp_bank_1); else n_pass++;
    n_tot++; if (fill_ready_1 !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", fill_ready_1); else n_pass++;
    n_tot++; if (frame_cnt_1 !== 16'd2) $display("FAIL bp_frame got %0d exp 2", frame_cnt_1); else n_pass++;
    n_tot++; if (comp_valid_1 !== 1'b1) $display("FAIL bp_comp_valid got %b exp 1", comp_valid_1); else n_pass++;
  endtask

  task automatic test_collision();
    addr_a = 3'd3; addr_b = 3'd3; din_a = 32'hAAAA5555; din_b = 32'h12345678; we_a = 1; we_b = 1;
    cyc();
    we_a = 0; we_b = 0;
    n_tot++; if (collision_1 !== 1'b1) $display("FAIL collision_pulse got %b exp 1", collision_1); else n_pass++;
    cyc();
    n_tot++; if (collision_1 !== 1'b0) $display("FAIL collision_clear got %b exp 0", collision_1); else n_pass++;
    n_tot++; if (dout_a_1 !== 32'hAAAA5555) $display("FAIL collision_winner got %h exp aaaa5555", dout_a_1); else n_pass++;
  endtask

  task automatic test_read_first();
    logic [31:0] old;
    old = m_mem[int'(!m_fb) * P + 5];
    addr_a = 3'd5; addr_b = 3'd5; din_a = 32'hDEADBEEF; we_a = 1;
    cyc();
    we_a = 0;
    n_tot++; if (dout_a_1 !== old) $display("FAIL rdfirst_a got %h exp %h", dout_a_1, old); else n_pass++;
    n_tot++; if (dout_b_1 !== old) $display("FAIL rdfirst_b got %h exp %h", dout_b_1, old); else n_pass++;
    cyc();
    n_tot++; if (dout_a_1 !== 32'hDEADBEEF) $display("FAIL rdfirst_new got %h exp deadbeef", dout_a_1); else n_pass++;
    n_tot++; if (dout_a_2 !== old) $display("FAIL rl2_lag got %h exp %h", dout_a_2, old); else n_pass++;
    cyc();
    n_tot++; if (dout_a_2 !== 32'hDEADBEEF) $display("FAIL rl2_new got %h exp deadbeef", dout_a_2); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      fill_valid = 1'($urandom_range(1));
      fill_data  = $urandom;
      comp_done  = ($urandom_range(11) == 0);
      addr_a     = AW'($urandom_range(P - 1));
      addr_b     = ($urandom_range(3) == 0) ? addr_a : AW'($urandom_range(P - 1));
      we_a       = ($urandom_range(2) == 0);
      we_b       = ($urandom_range(2) == 0);
      din_a      = $urandom;
      din_b      = $urandom;
      cyc();
      n_tot++; if (fill_ready_1 !== (m_cnt != P)) $display("FAIL rnd_fill_ready cyc %0d got %b exp %b", i, fill_ready_1, (m_cnt != P)); else n_pass++;
      n_tot++; if (comp_valid_1 !== m_busy || comp_bank_1 !== !m_fb) $display("FAIL rnd_comp cyc %0d got %b%b exp %b%b", i, comp_valid_1, comp_bank_1, m_busy, !m_fb); else n_pass++;
      n_tot++; if (frame_cnt_1 !== m_frame || frame_cnt_2 !== m_frame) $display("FAIL rnd_frame cyc %0d got %0d/%0d exp %0d", i, frame_cnt_1, frame_cnt_2, m_frame); else n_pass++;
      n_tot++; if (collision_1 !== m_coll || done_err_1 !== m_derr) $display("FAIL rnd_pulses cyc %0d got %b%b exp %b%b", i, collision_1, done_err_1, m_coll, m_derr); else n_pass++;
      if (ka1 && kb1) begin
        n_tot++; if (dout_a_1 !== ea1 || dout_b_1 !== eb1) $display("FAIL rnd_dout_rl1 cyc %0d got %h %h exp %h %h", i, dout_a_1, dout_b_1, ea1, eb1); else n_pass++;
      end
      if (ka2 && kb2) begin
        n_tot++; if (dout_a_2 !== ea2 || dout_b_2 !== eb2) $display("FAIL rnd_dout_rl2 cyc %0d got %h %h exp %h %h", i, dout_a_2, dout_b_2, ea2, eb2); else n_pass++;
      end
    end
    set_idle();
  endtask

  task automatic test_done_err();
    logic [15:0] frame_before;
    bit          bank_before;
    logic [31:0] old;
    int          tries;
    tries = 0;
    while (m_busy && tries < 4) begin
      comp_done = 1; cyc(); comp_done = 0; cyc();
      tries++;
    end
    n_tot++; if (comp_valid_1 !== 1'b0) $display("FAIL release_comp_valid got %b exp 0", comp_valid_1); else n_pass++;
    frame_before = m_frame; bank_before = !m_fb;
    comp_done = 1;
    cyc();
    comp_done = 0;
    n_tot++; if (done_err_1 !== 1'b1) $display("FAIL done_err_pulse got %b exp 1", done_err_1); else n_pass++;
    n_tot++; if (frame_cnt_1 !== frame_before || comp_bank_1 !== bank_before || comp_valid_1 !== 1'b0) $display("FAIL done_err_state got %0d %b %b exp %0d %b 0", frame_cnt_1, comp_bank_1, comp_valid_1, frame_before, bank_before); else n_pass++;
    cyc();
    n_tot++; if (done_err_1 !== 1'b0) $display("FAIL done_err_clear got %b exp 0", done_err_1); else n_pass++;
    old = m_mem[int'(!m_fb) * P + 2];
    addr_a = 3'd2; din_a = ~old; we_a = 1;
    cyc();
    we_a = 0;
    cyc();
    n_tot++; if (dout_a_1 !== old) $display("FAIL idle_write_dropped got %h exp %h", dout_a_1, old); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] samples [P];
    for (int i = 0; i < 4; i++) begin
      fill_valid = 1; fill_data = $urandom;
      cyc();
    end
    comp_done = 0;
    fill_valid = 1;
    rst_n = 0;
    #1;
    model_reset();
    n_tot++; if (fill_ready_1 !== 1'b1 || comp_valid_1 !== 1'b0 || comp_bank_1 !== 1'b1) $display("FAIL async_reset_ctrl got %b%b%b exp 101", fill_ready_1, comp_valid_1, comp_bank_1); else n_pass++;
    n_tot++; if (frame_cnt_1 !== 16'd0 || dout_a_1 !== 32'd0 || dout_b_2 !== 32'd0) $display("FAIL async_reset_data got %0d %h %h exp 0 0 0", frame_cnt_1, dout_a_1, dout_b_2); else n_pass++;
    cyc(); cyc();
    fill_valid = 0;
    rst_n = 1;
    for (int i = 0; i < P; i++) begin
      samples[i] = $urandom;
      fill_valid = 1; fill_data = samples[i];
      cyc();
    end
    fill_valid = 0;
    n_tot++; if (frame_cnt_1 !== 16'd1 || comp_bank_1 !== 1'b0 || comp_valid_1 !== 1'b1) $display("FAIL post_reset_swap got %0d %b %b exp 1 0 1", frame_cnt_1, comp_bank_1, comp_valid_1); else n_pass++;
    for (int i = 0; i < P; i++) begin
      addr_a = AW'(i); addr_b = AW'(P - 1 - i);
      cyc();
      n_tot++; if (dout_a_1 !== samples[i] || dout_b_1 !== samples[P - 1 - i]) $display("FAIL post_reset_data addr %0d got %h %h exp %h %h", i, dout_a_1, dout_b_1, samples[i], samples[P - 1 - i]); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    test_reset();
    test_fill_swap();
    test_backpressure();
    test_collision();
    test_read_first();
    test_random();
    test_done_err();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
